// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared FSM state encoding and default vectors for pc_sequencer.
package pc_seq_pkg;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h100;
endpackage

// File: rtl/pc_seq_ras.sv
// pc_seq_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_seq_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [W-1:0] top,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr, ptr_up;
  logic [PW:0]   count;
  assign ptr_up = ptr + 1'b1;
  assign top    = mem[ptr];
  assign empty  = count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && !pop) begin
      ptr   <= ptr_up;
      count <= (count == (PW+1)'(DEPTH)) ? count : count + 1'b1;
    end else if (pop && !push && !empty) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end
  // call+ret together rewrites the current top in place
  always_ff @(posedge clk)
    if (push) mem[pop ? ptr : ptr_up] <= data;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer with BOOT/RUN/HALT FSM; define PC_SEQ_RAS_EN for the return stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(DEF_TRAP_VEC),
  parameter int              RAS_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic              trap,
  input  logic              halt,
  input  logic              resume,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] Addr,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              pc_valid,
  output logic              misalign,
  output logic              ras_underflow,
  output logic [1:0]        state
);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
  state_t            cur, nxt_state;
  logic [ADDR_W-1:0] nxt_addr, target, ras_top;
  logic              nxt_mis, nxt_unf, ret_hit, ret_miss;
  assign pc_plus  = Addr + ADDR_W'(INSTR_BYTES);
  assign pc_valid = (cur == RUN) && !stall;
  assign state    = cur;
  assign target   = ret_hit ? ras_top : alu_result;
`ifdef PC_SEQ_RAS_EN
  logic ras_empty, act;
  assign act      = (cur == RUN) && !trap && jump;
  assign ret_hit  = ret && jump && !ras_empty;
  assign ret_miss = ret && jump && ras_empty;
  pc_seq_ras #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (act && call),
    .pop   (act && ret),
    .data  (pc_plus),
    .top   (ras_top),
    .empty (ras_empty)
  );
`else
  logic unused_ras;
  assign unused_ras = call ^ ret;
  assign ret_hit    = 1'b0;
  assign ret_miss   = 1'b0;
  assign ras_top    = '0;
`endif
  always_comb begin
    nxt_state = cur;
    nxt_addr  = Addr;
    nxt_mis   = 1'b0;
    nxt_unf   = 1'b0;
    if (trap) begin
      nxt_state = RUN;
      nxt_addr  = TRAP_VEC;
    end else if (cur == BOOT) begin
      nxt_state = RUN;
    end else if (cur == HALT) begin
      nxt_state = resume ? RUN : HALT;
    end else begin
      nxt_state = halt ? HALT : RUN;
      if (jump || branch_taken) begin
        nxt_mis  = (target & ALIGN_MASK) != '0;
        nxt_addr = nxt_mis ? TRAP_VEC : target;
        nxt_unf  = ret_miss;
      end else if (!stall && !halt) begin
        nxt_addr = pc_plus;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur           <= BOOT;
      Addr          <= RESET_VEC;
      misalign      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      cur           <= nxt_state;
      Addr          <= nxt_addr;
      misalign      <= nxt_mis;
      ras_underflow <= nxt_unf;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of pc_sequencer, plus an 8-bit instance for address wrap.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, trap, halt, resume, call, ret;
  logic [31:0] alu_result;
  logic [31:0] addr, pc_plus;
  logic        pc_valid, misalign, ras_underflow;
  logic [1:0]  state;
  logic [7:0]  addr8, pc_plus8;
  logic        pc_valid8, misalign8, ras_underflow8;
  logic [1:0]  state8;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .jump(jump),
    .alu_result(alu_result), .trap(trap), .halt(halt), .resume(resume), .call(call), .ret(ret),
    .Addr(addr), .pc_plus(pc_plus), .pc_valid(pc_valid), .misalign(misalign),
    .ras_underflow(ras_underflow), .state(state)
  );

  pc_sequencer #(.ADDR_W(8), .RESET_VEC(8'hFC), .TRAP_VEC(8'h80)) dut8 (
    .clk(clk), .rst(rst), .stall(1'b0), .branch_taken(1'b0), .jump(1'b0),
    .alu_result(8'h00), .trap(1'b0), .halt(1'b0), .resume(1'b0), .call(1'b0), .ret(1'b0),
    .Addr(addr8), .pc_plus(pc_plus8), .pc_valid(pc_valid8), .misalign(misalign8),
    .ras_underflow(ras_underflow8), .state(state8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {stall, branch_taken, jump, trap, halt, resume, call, ret} = '0;
  endtask

  task automatic go_to(input logic [31:0] a);
    jump = 1'b1;
    alu_result = a;
    step();
    jump = 1'b0;
    check("goto", addr, a);
  endtask

  initial begin
    idle();
    alu_result = '0;
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    check("rst_addr", addr, 32'h0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_valid", 32'(pc_valid), 32'd0);
    check("rst_mis", 32'(misalign), 32'd0);
    check("rst_unf", 32'(ras_underflow), 32'd0);
    check("w8_boot", 32'(addr8), 32'hFC);
    step();
    check("run_addr", addr, 32'h0);
    check("run_state", 32'(state), 32'd1);
    check("run_valid", 32'(pc_valid), 32'd1);
    check("w8_run", 32'(addr8), 32'hFC);
    step();
    check("seq4", addr, 32'h4);
    check("w8_wrap", 32'(addr8), 32'h00);
    check("w8_nofault", 32'(misalign8), 32'd0);
    step();
    check("seq8", addr, 32'h8);
    step();
    check("seq12", addr, 32'hC);
    step();
    check("seq16", addr, 32'h10);
    branch_taken = 1'b1;
    alu_result = 32'h40;
    step();
    check("br_addr", addr, 32'h40);
    check("br_mis", 32'(misalign), 32'd0);
    alu_result = 32'h42;
    step();
    check("mis_addr", addr, 32'h100);
    check("mis_pulse", 32'(misalign), 32'd1);
    branch_taken = 1'b0;
    step();
    check("mis_clear", 32'(misalign), 32'd0);
    check("mis_next", addr, 32'h104);
    go_to(32'h20);
    stall = 1'b1;
    #1;
    check("stall_valid", 32'(pc_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", addr, 32'h20);
    end
    trap = 1'b1;
    step();
    check("stall_trap", addr, 32'h100);
    idle();
    step();
    check("post_trap", addr, 32'h104);
    go_to(32'h30);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_state", 32'(state), 32'd2);
    check("halt_addr", addr, 32'h30);
    step();
    check("halt_hold", addr, 32'h30);
    check("halt_valid", 32'(pc_valid), 32'd0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("resume_state", 32'(state), 32'd1);
    step();
    check("resume_next", addr, 32'h34);
    halt = 1'b1;
    trap = 1'b1;
    step();
    idle();
    check("halt_trap_state", 32'(state), 32'd1);
    check("halt_trap_addr", addr, 32'h100);
    step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt2_addr", addr, 32'h104);
    trap = 1'b1;
    step();
    trap = 1'b0;
    check("htrap_state", 32'(state), 32'd1);
    check("htrap_addr", addr, 32'h100);
    halt = 1'b1;
    step();
    halt = 1'b0;
    rst = 1'b1;
    jump = 1'b1;
    alu_result = 32'h80;
    step();
    rst = 1'b0;
    jump = 1'b0;
    check("rst_halt_addr", addr, 32'h0);
    check("rst_halt_state", 32'(state), 32'd0);
    step();
    step();
    step();
    check("ras_pre", addr, 32'h8);
`ifdef PC_SEQ_RAS_EN
    call = 1'b1;
    go_to(32'h80);
    call = 1'b0;
    ret = 1'b1;
    go_to(32'hC);
    check("ret_unf0", 32'(ras_underflow), 32'd0);
    ret = 1'b0;
    call = 1'b1;
    for (int i = 2; i <= 6; i++) go_to(32'(i) << 8);
    call = 1'b0;
    ret = 1'b1;
    alu_result = 32'h700;
    for (int i = 5; i >= 2; i--) begin
      jump = 1'b1;
      step();
      check("ret_pop", addr, (32'(i) << 8) + 32'h4);
      check("ret_pop_unf", 32'(ras_underflow), 32'd0);
    end
    step();
    check("ret_empty", addr, 32'h700);
    check("ret_empty_unf", 32'(ras_underflow), 32'd1);
    idle();
    step();
    check("unf_clear", 32'(ras_underflow), 32'd0);
    check("unf_next", addr, 32'h704);
    call = 1'b1;
    go_to(32'h800);
    ret = 1'b1;
    jump = 1'b1;
    alu_result = 32'h900;
    step();
    call = 1'b0;
    check("callret_addr", addr, 32'h708);
    alu_result = 32'hA00;
    step();
    check("callret_top", addr, 32'h804);
    check("callret_unf", 32'(ras_underflow), 32'd0);
    step();
    check("callret_empty", addr, 32'hA00);
    check("callret_empty_unf", 32'(ras_underflow), 32'd1);
    idle();
`else
    call = 1'b1;
    go_to(32'h80);
    call = 1'b0;
    ret = 1'b1;
    go_to(32'h200);
    check("noras_unf", 32'(ras_underflow), 32'd0);
    idle();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, program-counter width in bits.
REQ-002 SHALL have parameter INSTR_BYTES, default 4, sequential increment; power of two.
REQ-003 SHALL have parameter RESET_VEC, default 0, first fetch address after reset.
REQ-004 SHALL have parameter TRAP_VEC, default 'h100, redirect target on trap or misaligned target.
REQ-005 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, 2..16.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-008 stall  in  1  hold Addr this cycle.
REQ-009 branch_taken  in  1  redirect to alu_result.
REQ-010 jump  in  1  unconditional redirect to alu_result.
REQ-011 alu_result  in  ADDR_W  branch/jump target.
REQ-012 trap  in  1  redirect to TRAP_VEC.
REQ-013 halt / resume  in  1 each  enter / leave HALT state.
REQ-014 call / ret  in  1 each  push / pop return stack (with jump).
REQ-015 Addr  out  ADDR_W  current fetch address, registered.
REQ-016 pc_plus  out  ADDR_W  Addr + INSTR_BYTES, combinational, wraps modulo 2^ADDR_W.
REQ-017 pc_valid  out  1  Addr is a valid fetch this cycle.
REQ-018 misalign / ras_underflow  out  1 each  single-cycle fault pulses, registered.
REQ-019 state  out  2  FSM state: BOOT=0, RUN=1, HALT=2.

Function
REQ-020 FSM SHALL be BOOT -> RUN unconditionally after one cycle; RUN -> HALT when halt=1; HALT -> RUN when resume=1; trap in HALT -> RUN.
REQ-021 pc_valid SHALL be 1 only in RUN with stall=0.
REQ-022 In RUN, next Addr priority SHALL be: trap > (jump|branch_taken) > stall > Addr+INSTR_BYTES.
REQ-023 Redirect SHALL take effect the next edge (1-cycle latency); trap and redirect SHALL override stall.
REQ-024 Redirect target with low log2(INSTR_BYTES) bits nonzero SHALL load TRAP_VEC and pulse misalign for one cycle.
REQ-025 In BOOT and HALT, Addr SHALL hold except trap, which loads TRAP_VEC.
REQ-026 Addr+INSTR_BYTES at 2^ADDR_W SHALL wrap to 0 without fault.
REQ-027 halt and trap in the same cycle SHALL take trap and stay in RUN.

Reset
REQ-028 On rst=1 at clk edge: Addr=RESET_VEC, state=BOOT, pc_valid=0, misalign=0, ras_underflow=0, RAS count=0.
REQ-029 rst SHALL override every other input, including mid-redirect or in HALT.

Configuration
REQ-030 With PC_SEQ_RAS_EN defined: call with jump SHALL push pc_plus; ret with jump SHALL load top-of-stack instead of alu_result and pop.
REQ-031 Push when full SHALL overwrite the oldest entry (circular); ret on empty SHALL use alu_result and pulse ras_underflow.
REQ-032 Simultaneous call and ret SHALL replace top-of-stack with pc_plus, count unchanged.
REQ-033 Without PC_SEQ_RAS_EN: call/ret SHALL be ignored, ras_underflow tied 0, no stack storage.

Structure
REQ-034 Package pc_seq_pkg SHALL hold the FSM state enum and the default vector constants.
REQ-035 Return stack SHALL be sub-module pc_seq_ras (pointer, count, storage), instantiated only under PC_SEQ_RAS_EN.

Verification
REQ-036 rst 1 cycle, idle -> Addr 0 (BOOT), 0 (RUN, valid), then 4, 8, 12.
REQ-037 At Addr=0x10, branch_taken, alu_result=0x40 -> next Addr 0x40; with alu_result=0x42 -> 0x100, misalign 1 cycle.
REQ-038 stall 3 cycles at 0x20 -> Addr holds 0x20, pc_valid 0; stall+trap -> 0x100.
REQ-039 halt at 0x30 -> state 2, Addr holds; resume -> state 1, Addr 0x34 next.
REQ-040 RAS_EN: call+jump at 0x8 to 0x80, ret+jump -> 0xC; 5 calls depth 4 then 5 rets -> 5th ret ras_underflow=1.
REQ-041 ADDR_W=8, Addr=0xFC, idle -> Addr 0x00, no fault.
